// File: rtl/panel_in_pkg.sv
// Front-panel input conditioner: shared types and defaults.
// Button FSM encodings and the default debounce depth.
package panel_in_pkg;

  localparam int DEBOUNCE_CNT_DEF = 1_000_000;
  localparam int SW_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  typedef struct packed {
    logic pulse;
    logic level;
  } btn_out_t;

endpackage

// File: rtl/panel_in_cond_if.sv
// Front-panel bundle: raw button/switches in, conditioned strobes out.
// master drives the raw inputs; slave is the conditioner.
interface panel_in_cond_if #(
  parameter int SW_W = 4
) ();

  logic            btn;
  logic [SW_W-1:0] sw;
  logic            btn_pulse;
  logic            btn_level;
  logic [SW_W-1:0] sw_stable;
  logic            sw_changed;

  modport master (
    output btn,
    output sw,
    input  btn_pulse,
    input  btn_level,
    input  sw_stable,
    input  sw_changed
  );

  modport slave (
    input  btn,
    input  sw,
    output btn_pulse,
    output btn_level,
    output sw_stable,
    output sw_changed
  );

endinterface

// File: rtl/panel_in_cond_sync_2ff.sv
// Two-flop synchroniser for asynchronous panel inputs.
// Both stages clear on reset so the bus starts at zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/panel_in_cond.sv
// Push-button and slide-switch conditioner feeding the SRAM control FSM.
// Synchronises, debounces, and emits one-cycle press/change strobes.
module panel_in_cond
  import panel_in_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int SW_W = SW_W_DEF
) (
  input logic            clock,
  input logic            reset,
  panel_in_cond_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            btn_s;
  logic [SW_W-1:0] sw_s;

  sync_2ff #(.W(1)) u_btn_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.btn),
    .q     (btn_s)
  );

  sync_2ff #(.W(SW_W)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.sw),
    .q     (sw_s)
  );

  btn_state_e     state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  btn_out_t       bout_q, bout_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bout_q  <= bout_d;
    end
  end

  // Pulse defaults low so it lives exactly one cycle after HELD entry.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    bout_d      = bout_q;
    bout_d.pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          bcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (bcnt_q == CNT_MAX) begin
          state_d      = HELD;
          bout_d.level = 1'b1;
          bout_d.pulse = 1'b1;
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          bcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (bcnt_q == CNT_MAX) begin
          state_d      = IDLE;
          bout_d.level = 1'b0;
        end else begin
          bcnt_d = bcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic [SW_W-1:0]  sw_cand;
  logic [SW_W-1:0]  sw_stable_q;
  logic [CNT_W-1:0] scnt;
  logic             sw_changed_q;

  // Any bit change restarts the window; counter saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cand      <= '0;
      sw_stable_q  <= '0;
      scnt         <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= 1'b0;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        scnt    <= '0;
      end else if (scnt == CNT_MAX) begin
        if (sw_cand != sw_stable_q) begin
          sw_stable_q  <= sw_cand;
          sw_changed_q <= 1'b1;
        end
      end else begin
        scnt <= scnt + CNT_ONE;
      end
    end
  end

  assign bus.btn_pulse  = bout_q.pulse;
  assign bus.btn_level  = bout_q.level;
  assign bus.sw_stable  = sw_stable_q;
  assign bus.sw_changed = sw_changed_q;

endmodule

// File: tb/tb_panel_in_cond.sv
// Directed bench for panel_in_cond with DEBOUNCE_CNT=4.
// Expected edge positions are hand-derived from the press/switch timing.
module tb_panel_in_cond;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  panel_in_cond_if #(.SW_W(4)) bus ();

  panel_in_cond #(
    .DEBOUNCE_CNT (4),
    .SW_W         (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.btn = 1'b0;
    bus.sw  = 4'h0;
    tick();
    tick();
    n_cmp++;
    if ({bus.btn_pulse, bus.btn_level,
         bus.sw_changed, bus.sw_stable} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 0",
        {bus.btn_pulse, bus.btn_level,
         bus.sw_changed, bus.sw_stable});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_clean_press();
    int np;
    bus.btn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if ({bus.btn_pulse, bus.btn_level} !== 2'b00) begin
      n_bad++;
      $display("FAIL press_early got %b want 00",
        {bus.btn_pulse, bus.btn_level});
    end
    tick();
    n_cmp++;
    if ({bus.btn_pulse, bus.btn_level} !== 2'b11) begin
      n_bad++;
      $display("FAIL press_edge6 got %b want 11",
        {bus.btn_pulse, bus.btn_level});
    end
    tick();
    n_cmp++;
    if ({bus.btn_pulse, bus.btn_level} !== 2'b01) begin
      n_bad++;
      $display("FAIL press_edge7 got %b want 01",
        {bus.btn_pulse, bus.btn_level});
    end
    np = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.btn_pulse === 1'b1) np++;
    end
    n_cmp++;
    if (np !== 0 || bus.btn_level !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_no_repeat pulses %0d lvl %b want 0 1",
        np, bus.btn_level);
    end
    bus.btn = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    n_cmp++;
    if (bus.btn_level !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_release got %b want 0",
        bus.btn_level);
    end
  endtask

  task automatic test_bounce();
    int np;
    int pos;
    np = 0;
    bus.btn = 1'b1; tick();
    if (bus.btn_pulse === 1'b1) np++;
    bus.btn = 1'b0; tick(); tick();
    if (bus.btn_pulse === 1'b1) np++;
    bus.btn = 1'b1; tick(); tick(); tick();
    if (bus.btn_pulse === 1'b1) np++;
    bus.btn = 1'b0; tick();
    if (bus.btn_pulse === 1'b1) np++;
    bus.btn = 1'b1;
    pos = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.btn_pulse === 1'b1) begin
        np++;
        pos = i;
      end
    end
    n_cmp++;
    if (np !== 1 || pos !== 7) begin
      n_bad++;
      $display("FAIL bounce pulses %0d at %0d want 1 at 7",
        np, pos);
    end
  endtask

  task automatic test_release_glitch();
    int np;
    int nlow;
    np = 0;
    nlow = 0;
    bus.btn = 1'b0;
    tick(); tick();
    bus.btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.btn_pulse === 1'b1) np++;
      if (bus.btn_level !== 1'b1) nlow++;
    end
    n_cmp++;
    if (np !== 0 || nlow !== 0) begin
      n_bad++;
      $display("FAIL rel_glitch pulses %0d low %0d want 0 0",
        np, nlow);
    end
    bus.btn = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (bus.btn_level !== 1'b1) begin
      n_bad++;
      $display("FAIL release_early got %b want 1",
        bus.btn_level);
    end
    tick();
    n_cmp++;
    if (bus.btn_level !== 1'b0) begin
      n_bad++;
      $display("FAIL release_edge6 got %b want 0",
        bus.btn_level);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_switches();
    int nc;
    int pos;
    int nbadv;
    bus.sw = 4'hA;
    nc = 0;
    pos = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) begin
        n_cmp++;
        if (bus.sw_stable !== 4'h0) begin
          n_bad++;
          $display("FAIL sw_early got %h want 0",
            bus.sw_stable);
        end
      end
      if (bus.sw_changed === 1'b1) begin
        nc++;
        pos = i;
      end
    end
    n_cmp++;
    if (nc !== 1 || pos !== 7 || bus.sw_stable !== 4'hA) begin
      n_bad++;
      $display("FAIL sw_A chg %0d at %0d val %h want 1 7 a",
        nc, pos, bus.sw_stable);
    end
    bus.sw = 4'hF;
    tick();
    bus.sw = 4'h5;
    nc = 0;
    pos = -1;
    nbadv = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.sw_changed === 1'b1) begin
        nc++;
        pos = i;
      end
      if (bus.sw_stable !== 4'hA && bus.sw_stable !== 4'h5)
        nbadv++;
    end
    n_cmp++;
    if (nc !== 1 || pos !== 7 || nbadv !== 0 ||
        bus.sw_stable !== 4'h5) begin
      n_bad++;
      $display("FAIL sw_glitch chg %0d at %0d bad %0d val %h want 1 7 0 5",
        nc, pos, nbadv, bus.sw_stable);
    end
  endtask

  task automatic test_reset_mid();
    int np;
    int pp;
    int nc;
    int cp;
    bus.btn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.btn_pulse, bus.btn_level,
         bus.sw_changed, bus.sw_stable} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_mid got %b want 0",
        {bus.btn_pulse, bus.btn_level,
         bus.sw_changed, bus.sw_stable});
    end
    tick(); tick();
    reset = 1'b0;
    np = 0; pp = -1; nc = 0; cp = -1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.btn_pulse === 1'b1) begin
        np++;
        pp = i;
      end
      if (bus.sw_changed === 1'b1) begin
        nc++;
        cp = i;
      end
    end
    n_cmp++;
    if (np !== 1 || pp !== 7) begin
      n_bad++;
      $display("FAIL reset_repress pulses %0d at %0d want 1 at 7",
        np, pp);
    end
    n_cmp++;
    if (nc !== 1 || cp !== 7 || bus.sw_stable !== 4'h5) begin
      n_bad++;
      $display("FAIL reset_sw chg %0d at %0d val %h want 1 7 5",
        nc, cp, bus.sw_stable);
    end
    bus.btn = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_simultaneous();
    int nboth;
    int pos;
    bus.btn = 1'b1;
    bus.sw  = 4'h3;
    nboth = 0;
    pos = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.btn_pulse === 1'b1 && bus.sw_changed === 1'b1) begin
        nboth++;
        pos = i;
      end
    end
    n_cmp++;
    if (nboth !== 1 || pos !== 7 || bus.sw_stable !== 4'h3) begin
      n_bad++;
      $display("FAIL simultaneous both %0d at %0d val %h want 1 7 3",
        nboth, pos, bus.sw_stable);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_switches();
    test_reset_mid();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/panel_in_cond.md
# panel_in_cond

Front-panel input conditioner that sits directly upstream of the SRAM read/write control FSM. It synchronises the raw push-button and 4-bit slide switches, then debounces them with counter-based FSMs. It delivers a single-cycle confirmed-press pulse, which is the FSM's state-advance strobe, plus a stable switch bus used as address and write data. One instance serves one button plus its switch bank.

## Interface
- `DEBOUNCE_CNT`, default 1_000_000: stable cycles required to accept a level change. Minimum 2; benches use 4.
- `SW_W`, default 4: switch bus width.
- `CNT_W`, default $clog2(DEBOUNCE_CNT): local, derived counter width, not overridable.

Ports:
- `clock`, in, 1: single system clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `btn`, in, 1: raw push-button; asynchronous, bouncing.
- `sw`, in, SW_W: raw slide switches; asynchronous, bouncing.
- `btn_pulse`, out, 1: one-cycle strobe per accepted press.
- `btn_level`, out, 1: debounced button level.
- `sw_stable`, out, SW_W: debounced switch value.
- `sw_changed`, out, 1: one-cycle strobe when `sw_stable` updates.

## Operation
- **Synchroniser.** `btn` and `sw` each pass through a 2-FF synchroniser, reset to 0. Downstream logic uses only the synchronised signals `btn_s` and `sw_s`.
- **Button FSM.** Uses a shared counter `bcnt`; states are IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: `btn_s`=1 moves to PRESS_WAIT with `bcnt`=0.
  - PRESS_WAIT: `btn_s`=0 returns to IDLE (bounce rejected). Otherwise, if `bcnt`==DEBOUNCE_CNT-1, move to HELD, set `btn_level`=1 and `btn_pulse`=1. Otherwise increment `bcnt`.
  - HELD: `btn_s`=0 moves to RELEASE_WAIT with `bcnt`=0. `btn_pulse` is cleared the cycle after entry.
  - RELEASE_WAIT: `btn_s`=1 returns to HELD with no pulse. If `bcnt`==DEBOUNCE_CNT-1, move to IDLE and set `btn_level`=0. Otherwise increment `bcnt`.
- **Switch debounce.** Uses a candidate register `sw_cand` and counter `scnt`, independent of the button.
  - If `sw_s`≠`sw_cand`: load `sw_cand`←`sw_s` and set `scnt`=0.
  - Else if `scnt`==DEBOUNCE_CNT-1 and `sw_cand`≠`sw_stable`: set `sw_stable`←`sw_cand` and pulse `sw_changed` for 1 cycle.
  - Else if `scnt`<DEBOUNCE_CNT-1: increment `scnt`. The counter saturates at DEBOUNCE_CNT-1.
- **Outputs.** All outputs are registered; no combinational path from inputs to outputs.
- **Reset values.** Every output and every internal register is 0; the button FSM is in IDLE.
- **Boundary cases.**
  - A held button produces exactly one pulse, no auto-repeat.
  - A button glitch shorter than DEBOUNCE_CNT cycles produces no pulse and no `btn_level` change.
  - A release glitch shorter than DEBOUNCE_CNT produces no second pulse.
  - Counters never wrap: they compare at DEBOUNCE_CNT-1 and either transition or saturate.
  - Non-zero switches at reset release produce a `sw_stable` update and a `sw_changed` pulse after debounce.
  - Reset asserted mid-PRESS_WAIT, or at any point, immediately forces IDLE and zero outputs. After release, a still-held button needs a full new debounce and then pulses once.

## Timing
- Let edge 0 be the first edge sampling raw `btn`=1, with the input held high:
  - `btn_s`=1 after edge 1.
  - PRESS_WAIT entered at edge 2.
  - `btn_pulse` high during the cycle after edge DEBOUNCE_CNT+2 and low after edge DEBOUNCE_CNT+3.
  - `btn_level` rises together with `btn_pulse`.
- Release mirrors press: `btn_level` falls after edge DEBOUNCE_CNT+2, counted from the first edge sampling raw `btn`=0.
- Switch latency follows the same DEBOUNCE_CNT+2 edge count from the first edge sampling the new value. It restarts whenever any bit changes.
- `btn_pulse` and `sw_changed` are each exactly 1 cycle wide. They may be asserted in the same cycle.

## Structure
- Shared package `panel_in_pkg` holds:
  - the button-state encodings (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - the default DEBOUNCE_CNT constant, so the panel-level top and benches override it consistently.
- One sub-module, `sync_2ff`, parameterised by width and with active-high asynchronous reset. It is instantiated twice: width 1 for the button, SW_W for the switches.

## Test plan
All scenarios use DEBOUNCE_CNT=4.
- **Clean press.** Reset, then hold `btn`=1 → `btn_pulse`=1 for exactly one cycle after edge 6, `btn_level`=1 from then on. Hold 50 cycles → no further pulse.
- **Bounce.** `btn` toggles 1,0,1,0 at cycle spacing 1–3, then holds 1 → exactly one pulse, 6 edges after the final rising sample.
- **Release glitch.** In HELD, drive `btn`=0 for 2 cycles, then back to 1 → `btn_level` stays 1 and no pulse. Then release for 10 cycles → `btn_level`=0 after edge 6.
- **Switches.** Change `sw` 0→4'hA → `sw_stable`=4'hA and a single `sw_changed` pulse at edge 6. A 4'hA→4'h5 change with a 1-cycle 4'hF glitch → `sw_stable` goes to 4'h5 only, with one pulse.
- **Reset mid-operation.** Assert `reset` in PRESS_WAIT (`bcnt`=2) → all outputs 0 immediately. Release with `btn` still 1 → one pulse after a full new debounce.
- **Simultaneous events.** Press and switch change on the same edge → `btn_pulse` and `sw_changed` both assert in the same cycle.
